// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder.
//   state_e  : feeder FSM states
//   MacLat   : cycles from operand presentation to inclusion in the mac output
//   DefWidth : default operand/result width
//   DefDepth : default maximum vector length
package mac_pkg;

  localparam int unsigned MacLat   = 3;
  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/operand_buffer.sv
// Activation and weight register files sharing one write port and one read index.
//   clk, rstb : clock, async active-low reset (contents cleared to 0)
//   we_i      : write strobe
//   sel_i     : 0 = activation file, 1 = weight file
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : shared read index
//   act_o     : activation at raddr_i (combinational read)
//   wt_o      : weight at raddr_i (combinational read)
module operand_buffer
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              we_i,
  input  logic              sel_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  act_o,
  output logic [WIDTH-1:0]  wt_o
);

  logic [WIDTH-1:0] act_q [DEPTH];
  logic [WIDTH-1:0] wt_q  [DEPTH];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        act_q[i] <= '0;
        wt_q[i]  <= '0;
      end
    end else if (we_i) begin
      if (sel_i) wt_q[waddr_i]  <= wdata_i;
      else       act_q[waddr_i] <= wdata_i;
    end
  end

  assign act_o = act_q[raddr_i];
  assign wt_o  = wt_q[raddr_i];

endmodule

// File: rtl/mac_feeder.sv
// Streams stored activation/weight vectors into an external pipelined mac and
// captures the accumulated dot product once the pipeline has drained.
//   clk, rstb            : clock, async active-low reset
//   load_en/sel/addr/data: operand buffer write port (ignored while busy)
//   start, len           : begin a dot product of len elements (clamped to DEPTH)
//   busy, done           : operation in progress / one-cycle completion pulse
//   result               : captured dot product, held until next capture
//   mac_a, mac_b         : operands presented to the mac
//   mac_clear_n          : active-low mac accumulator clear
//   mac_out              : accumulated output returned by the mac
// All outputs are registered: next values are decoded alongside the next state.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned MAC_LAT = MacLat
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    load_en,
  input  logic                    load_sel,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic signed [WIDTH-1:0] load_data,
  input  logic                    start,
  input  logic [ADDR_W:0]         len,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic signed [WIDTH-1:0] mac_a,
  output logic signed [WIDTH-1:0] mac_b,
  output logic                    mac_clear_n,
  input  logic signed [WIDTH-1:0] mac_out
);

  localparam int unsigned    DrW    = $clog2(MAC_LAT + 1);
  localparam logic [ADDR_W:0] LenMax = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] IdxOne = (ADDR_W + 1)'(1);
  localparam logic [DrW-1:0]  DrLast = DrW'(MAC_LAT - 1);
  localparam logic [DrW-1:0]  DrOne  = DrW'(1);

  state_e state_q, state_d;
  logic [ADDR_W:0] len_q, len_d, len_eff;
  logic [ADDR_W:0] idx_q, idx_d;  // index of the next element to present
  logic [DrW-1:0]  dcnt_q, dcnt_d;
  logic            busy_q, busy_d, done_q, done_d, clr_n_q, clr_n_d;
  logic signed [WIDTH-1:0] result_q, result_d, mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [WIDTH-1:0] act_rd, wt_rd;
  logic             buf_we;

  // Buffers are frozen for the whole busy window; IDLE and DONE accept writes.
  assign buf_we  = load_en && (state_q == StIdle || state_q == StDone);
  assign len_eff = (len > LenMax) ? LenMax : len;

  operand_buffer #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rstb    (rstb),
    .we_i    (buf_we),
    .sel_i   (load_sel),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (idx_q[ADDR_W-1:0]),
    .act_o   (act_rd),
    .wt_o    (wt_rd)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    dcnt_d   = dcnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    clr_n_d  = 1'b1;
    result_d = result_q;
    mac_a_d  = '0;
    mac_b_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            state_d  = StDone;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = StClear;
            len_d   = len_eff;
            idx_d   = '0;
            busy_d  = 1'b1;
            clr_n_d = 1'b0;
          end
        end
      end
      StClear: begin
        state_d = StFeed;
        busy_d  = 1'b1;
        mac_a_d = act_rd;
        mac_b_d = wt_rd;
        idx_d   = idx_q + IdxOne;
      end
      StFeed: begin
        busy_d = 1'b1;
        if (idx_q == len_q) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          mac_a_d = act_rd;
          mac_b_d = wt_rd;
          idx_d   = idx_q + IdxOne;
        end
      end
      StDrain: begin
        if (dcnt_q == DrLast) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = mac_out;
        end else begin
          dcnt_d = dcnt_q + DrOne;
          busy_d = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= StIdle;
      len_q    <= '0;
      idx_q    <= '0;
      dcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_n_q  <= 1'b1;
      result_q <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      dcnt_q   <= dcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clr_n_q  <= clr_n_d;
      result_q <= result_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign mac_a       = mac_a_q;
  assign mac_b       = mac_b_q;
  assign mac_clear_n = clr_n_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: a behavioural mac with a 3-cycle latency closes the
// loop, and a reference model of the operand buffers predicts each dot product.
module tb_mac_feeder;

  localparam int W   = 16;
  localparam int D   = 16;
  localparam int AW  = 4;
  localparam int LAT = 3;

  logic clk = 1'b0, rstb = 1'b0;
  logic load_en = 1'b0, load_sel = 1'b0, start = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic signed [W-1:0] load_data = '0;
  logic [AW:0] len = '0;
  logic busy, done, mac_clear_n;
  logic signed [W-1:0] result, mac_a, mac_b, mac_out;

  int n_cmp = 0, n_err = 0;
  int act_m [D];
  int wt_m  [D];

  always #5 clk = ~clk;

  mac_feeder #(
    .WIDTH   (W),
    .DEPTH   (D),
    .ADDR_W  (AW),
    .MAC_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .load_en     (load_en),
    .load_sel    (load_sel),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_clear_n (mac_clear_n),
    .mac_out     (mac_out)
  );

  // Behavioural mac: product of cycle k is visible in mac_out from cycle k+3.
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   p0, p1, acc;
  assign prod    = mac_a * mac_b;
  assign mac_out = acc;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p0 <= '0; p1 <= '0; acc <= '0;
    end else if (!mac_clear_n) begin
      p0 <= '0; p1 <= '0; acc <= '0;
    end else begin
      p0  <= prod[W-1:0];
      p1  <= p0;
      acc <= acc + p1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [W-1:0] ref_dot(input int l);
    longint s;
    s = 0;
    for (int i = 0; i < l; i++) s += longint'(act_m[i]) * longint'(wt_m[i]);
    return s[W-1:0];
  endfunction

  task automatic load(input bit sel, input int addr, input logic signed [W-1:0] data);
    @(negedge clk);
    load_en = 1'b1; load_sel = sel; load_addr = addr[AW-1:0]; load_data = data;
    if (sel) wt_m[addr] = int'(data);
    else     act_m[addr] = int'(data);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < D; i++) begin
      act_m[i] = 0;
      wt_m[i]  = 0;
    end
  endtask

  // One full operation; optional write coinciding with start, optional mid-run disturbance.
  task automatic run_op(input int l, input bit perturb, input bit co_load, input bit c_sel,
                        input int c_addr, input logic signed [W-1:0] c_data);
    int leff, exp_lat, cyc, clr_cnt, busy_cnt, feed_bad, k;
    logic signed [W-1:0] exp_r;
    logic [31:0] r;
    leff = (l > D) ? D : l;
    @(negedge clk);
    start = 1'b1; len = l[AW:0];
    if (co_load) begin
      load_en = 1'b1; load_sel = c_sel; load_addr = c_addr[AW-1:0]; load_data = c_data;
      if (c_sel) wt_m[c_addr] = int'(c_data);
      else       act_m[c_addr] = int'(c_data);
    end
    exp_r   = ref_dot(leff);
    exp_lat = (leff == 0) ? 1 : leff + LAT + 2;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    cyc = 1; clr_cnt = 0; busy_cnt = 0; feed_bad = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (mac_clear_n === 1'b0) clr_cnt++;
      if (busy === 1'b1) busy_cnt++;
      k = cyc - 2;
      if (k >= 0 && k < leff) begin
        if (mac_a !== act_m[k][W-1:0] || mac_b !== wt_m[k][W-1:0]) feed_bad++;
      end else if (mac_a !== '0 || mac_b !== '0) begin
        feed_bad++;
      end
      if (perturb && cyc == 3) begin
        r = $urandom;
        start = 1'b1; len = 5'd1;
        load_en = 1'b1; load_sel = r[20]; load_addr = r[19:16]; load_data = r[15:0];
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; load_en = 1'b0;
    if (mac_clear_n === 1'b0) clr_cnt++;
    chk("latency", cyc, exp_lat);
    chk("result", result, exp_r);
    chk("busy_at_done", busy, 0);
    chk("clear_cycles", clr_cnt, (leff == 0) ? 0 : 1);
    chk("busy_cycles", busy_cnt, (leff == 0) ? 0 : exp_lat - 1);
    chk("feed_operands", feed_bad, 0);
    // start presented during DONE must be ignored
    start = 1'b1; len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("result_hold", result, exp_r);
    @(negedge clk);
    chk("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    logic [31:0] r;
    int n;
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    chk("rst_clear_n", mac_clear_n, 1);
    rstb = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, 16'(i + 1));
      load(1'b1, i, 16'(i + 5));
    end
    run_op(4, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("dot_1234_5678", result, 70);
    run_op(4, 1'b1, 1'b0, 1'b0, 0, '0);
    chk("perturbed_repeat", result, 70);

    load(1'b0, 0, -16'sd3); load(1'b0, 1, 16'sd7);
    load(1'b1, 0, 16'sd4);  load(1'b1, 1, -16'sd2);
    run_op(2, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("signed_dot", result, -26);

    load(1'b0, 0, 16'sd300); load(1'b1, 0, 16'sd300);
    run_op(1, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("wrap_dot", result, 24464);

    run_op(0, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("len0_result", result, 0);

    // write coinciding with start must be visible to element 0
    run_op(1, 1'b0, 1'b1, 1'b0, 0, 16'sd11);
    chk("load_with_start", result, 3300);

    for (int i = 0; i < D; i++) begin
      r = $urandom; load(1'b0, i, r[15:0]);
      r = $urandom; load(1'b1, i, r[15:0]);
    end
    run_op(20, 1'b0, 1'b0, 1'b0, 0, '0);

    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) begin
        r = $urandom;
        load(r[20], int'(r[19:16]), r[15:0]);
      end
      r = $urandom;
      run_op($urandom_range(0, 20), r[24], r[25], r[20], int'(r[19:16]), r[15:0]);
    end

    // reset in the middle of DRAIN
    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, 16'(i + 1));
      load(1'b1, i, 16'(i + 5));
    end
    @(negedge clk);
    start = 1'b1; len = 5'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rstb = 1'b0;
    clear_model();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_mac_a", mac_a, 0);
    chk("mid_rst_mac_b", mac_b, 0);
    chk("mid_rst_clear_n", mac_clear_n, 1);
    @(negedge clk);
    rstb = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) n++;
    end
    chk("no_done_after_rst", n, 0);
    run_op(4, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("buffers_cleared", result, 0);
    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, 16'(i + 1));
      load(1'b1, i, 16'(i + 5));
    end
    run_op(4, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("post_rst_dot", result, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
